regfile_16_onehot: RTL and testbench
====================================

Name: regfile_16_onehot

Overview:
- 16-entry register file whose write port takes the 16-bit one-hot write-select vector produced by the 4-to-16 write decoder.
- Two read ports with 1-cycle registered outputs, write-first bypass and per-entry valid bits.
- Flags malformed (non-one-hot) write vectors.
- Sits directly downstream of the decoder in the datapath register-bank.

Parameters:
- DATA_W, 16, width of each register and of write/read data.
- ZERO_R0, 0, 1 = entry 0 hardwired to zero (writes ignored, always valid).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_sel  in  16  one-hot write select from decoder; all-zero = no write.
- wr_data  in  DATA_W  write data, sampled on clk edge.
- clr_valid  in  1  synchronous clear of all valid bits.
- rd_addr_a  in  4  read port A address.
- rd_addr_b  in  4  read port B address.
- rd_data_a  out  DATA_W  registered read data, port A.
- rd_data_b  out  DATA_W  registered read data, port B.
- rd_vld_a  out  1  registered valid bit of the entry read on port A.
- rd_vld_b  out  1  registered valid bit of the entry read on port B.
- wr_err  out  1  1-cycle pulse: previous cycle's wr_sel had ≥2 bits set.
- valid_map  out  16  current valid bit per entry (register state, no extra delay).

Behaviour:
- Reset (async assert, release synchronous to clk):
  - all 16 registers = 0.
  - valid_map = 0 (bit0 = 1 if ZERO_R0).
  - rd_data_a/b = 0, rd_vld_a/b = 0, wr_err = 0.
- Write classification each edge:
  - wr_sel == 0: no write, no error.
  - exactly one bit set: write to that entry.
  - ≥2 bits set: no entry written, valid_map unchanged, wr_err = 1 for the following cycle only.
- Legal write to entry i: reg[i] <= wr_data and valid_map[i] <= 1 at the edge.
  - ZERO_R0 = 1 and i = 0: write dropped silently, no error.
- Read (both ports identical and independent):
  - at each edge, rd_data_x <= reg[rd_addr_x] and rd_vld_x <= valid_map[rd_addr_x]; latency 1 cycle.
  - write-first bypass: if the same edge performs a legal write to rd_addr_x, rd_data_x <= wr_data and rd_vld_x <= 1.
  - both ports may read the same address; both get the same values.
  - ZERO_R0 = 1 and addr 0: data 0, vld 1, regardless of writes.
- clr_valid:
  - at the edge, valid_map <= 0 (bit0 stays 1 if ZERO_R0); register contents are retained.
  - clr_valid and a legal write in the same cycle: clear wins, the written entry's valid = 0, data is still written.
  - bypassed read in that cycle returns wr_data with vld = 0.
  - reads in the clear cycle without a write hit return pre-clear valid bits.
- wr_err does not accumulate; back-to-back bad vectors give back-to-back pulses.
- Reset asserted mid-operation: immediate return to reset values; pending write in that cycle is lost.
- No combinational path from any input to any output.

Decomposition:
- Shared package: NUM_REGS = 16, ADDR_W = 4, and a one-hot check function (popcount ≤ 1) reused by other decoder consumers.
- One sub-module is natural: regfile_read_port (address mux, bypass compare, output registers), instantiated twice.
- Write logic and valid_map stay in the top module.

Test Plan:
- Reset, then read addr 5 on A and addr 9 on B -> rd_data 0x0000, rd_vld 0, valid_map 0x0000.
- wr_sel = 0x0020 with wr_data 0xBEEF, then read A addr 5 next cycle -> rd_data_a 0xBEEF, rd_vld_a 1, valid_map 0x0020.
- Same-cycle wr_sel = 0x0008 with wr_data 0x1234 while rd_addr_a = 3 -> rd_data_a 0x1234, rd_vld_a 1 on the very next edge (bypass).
- wr_sel = 0x0011 with wr_data 0xFFFF -> wr_err 1 for exactly one cycle; entries 0 and 4 keep prior data; valid_map unchanged.
- Entry 5 valid, assert clr_valid with wr_sel = 0x0400, wr_data 0x00AA -> valid_map 0x0000; subsequent read addr 10 gives 0x00AA with vld 0.
- ZERO_R0 = 1: wr_sel = 0x0001, wr_data 0x5555, then read addr 0 -> rd_data 0x0000, vld 1, wr_err 0.

Source files
------------

// File: rtl/regfile_16_onehot_pkg.sv
// rtl/regfile_16_onehot_pkg.sv - shared sizes and one-hot check for write-decoder consumers
package regfile_16_onehot_pkg;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;

    // True when at most one bit is set (all-zero counts as a legal "no write").
    function automatic logic is_onehot0(input logic [NUM_REGS-1:0] v);
        return (v & (v - {{(NUM_REGS-1){1'b0}}, 1'b1})) == '0;
    endfunction

endpackage

// File: rtl/regfile_16_onehot_read_port.sv
// rtl/regfile_16_onehot_read_port.sv - registered read port with write-first bypass
module regfile_16_onehot_read_port
    import regfile_16_onehot_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_W-1:0]                rd_addr,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
    input  logic [NUM_REGS-1:0]              valid_map,
    input  logic [NUM_REGS-1:0]              wr_en,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic                             clr_valid,
    output logic [DATA_W-1:0]                rd_data,
    output logic                             rd_vld
);

    logic wr_hit;

    // wr_en already excludes illegal vectors and a hardwired entry 0.
    assign wr_hit = wr_en[rd_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else if (wr_hit) begin
            rd_data <= wr_data;
            rd_vld  <= ~clr_valid;
        end else begin
            rd_data <= regs[rd_addr];
            rd_vld  <= valid_map[rd_addr];
        end
    end

endmodule

// File: rtl/regfile_16_onehot.sv
// rtl/regfile_16_onehot.sv - 16-entry register file with one-hot write select and valid bits
module regfile_16_onehot
    import regfile_16_onehot_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REGS-1:0] wr_sel,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                clr_valid,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    output logic                rd_vld_a,
    output logic                rd_vld_b,
    output logic                wr_err,
    output logic [NUM_REGS-1:0] valid_map
);

    localparam logic [NUM_REGS-1:0] R0_MASK = {{(NUM_REGS-1){1'b0}}, ZERO_R0};

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [NUM_REGS-1:0]             valid_q;
    logic [NUM_REGS-1:0]             wr_en;
    logic                            wr_ok;

    assign wr_ok     = is_onehot0(wr_sel);
    assign wr_en     = wr_ok ? (wr_sel & ~R0_MASK) : '0;
    assign valid_map = valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Clear takes priority over a same-cycle write; a hardwired entry 0 stays valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= R0_MASK;
        end else if (clr_valid) begin
            valid_q <= R0_MASK;
        end else begin
            valid_q <= valid_q | wr_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= ~wr_ok;
        end
    end

    regfile_16_onehot_read_port #(.DATA_W(DATA_W)) u_port_a (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr_a),
        .regs      (regs),
        .valid_map (valid_q),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .clr_valid (clr_valid),
        .rd_data   (rd_data_a),
        .rd_vld    (rd_vld_a)
    );

    regfile_16_onehot_read_port #(.DATA_W(DATA_W)) u_port_b (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr_b),
        .regs      (regs),
        .valid_map (valid_q),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .clr_valid (clr_valid),
        .rd_data   (rd_data_b),
        .rd_vld    (rd_vld_b)
    );

endmodule

// File: tb/tb_regfile_16_onehot.sv
// tb/tb_regfile_16_onehot.sv - table and random checks of regfile_16_onehot, ZERO_R0 = 0 and 1
module tb_regfile_16_onehot;

    localparam int DW = 16;

    typedef struct {
        logic [15:0] ws;
        logic [15:0] wd;
        logic        clr;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [15:0] da;
        logic        va;
        logic [15:0] db;
        logic        vb;
        logic        err;
        logic [15:0] vmap;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   wr_sel = '0;
    logic [DW-1:0] wr_data = '0;
    logic          clr_valid = 1'b0;
    logic [3:0]    rd_addr_a = '0;
    logic [3:0]    rd_addr_b = '0;

    logic [DW-1:0] rda [2];
    logic [DW-1:0] rdb [2];
    logic          va  [2];
    logic          vb  [2];
    logic          err [2];
    logic [15:0]   vmap[2];

    logic [DW-1:0] mem [2][16];
    logic          vmb [2][16];
    logic [DW-1:0] e_da [2];
    logic [DW-1:0] e_db [2];
    logic          e_va [2];
    logic          e_vb [2];
    logic          e_err[2];
    logic [15:0]   e_vm [2];

    int nvec = 0;
    int nerr = 0;
    vec_t tbl[11];

    always #5 clk = ~clk;

    regfile_16_onehot #(.DATA_W(DW), .ZERO_R0(1'b0)) dut0 (
        .clk(clk), .rst(rst), .wr_sel(wr_sel), .wr_data(wr_data), .clr_valid(clr_valid),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda[0]), .rd_data_b(rdb[0]), .rd_vld_a(va[0]), .rd_vld_b(vb[0]),
        .wr_err(err[0]), .valid_map(vmap[0])
    );

    regfile_16_onehot #(.DATA_W(DW), .ZERO_R0(1'b1)) dut1 (
        .clk(clk), .rst(rst), .wr_sel(wr_sel), .wr_data(wr_data), .clr_valid(clr_valid),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rda[1]), .rd_data_b(rdb[1]), .rd_vld_a(va[1]), .rd_vld_b(vb[1]),
        .wr_err(err[1]), .valid_map(vmap[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int z = 0; z < 2; z++) begin
            for (int i = 0; i < 16; i++) begin
                mem[z][i] = '0;
                vmb[z][i] = (z == 1 && i == 0);
            end
            e_da[z] = '0; e_db[z] = '0; e_va[z] = 1'b0; e_vb[z] = 1'b0; e_err[z] = 1'b0;
            e_vm[z] = (z == 1) ? 16'h0001 : 16'h0000;
        end
    endtask

    task automatic model_read(input int z, input int a, input logic eff, input int idx,
                              output logic [DW-1:0] d, output logic v);
        if (z == 1 && a == 0) begin
            d = '0; v = 1'b1;
        end else if (eff && idx == a) begin
            d = wr_data; v = !clr_valid;
        end else begin
            d = mem[z][a]; v = vmb[z][a];
        end
    endtask

    // Expected outputs after the coming edge, computed from the pre-edge state.
    task automatic model_edge();
        int cnt;
        int idx;
        logic eff;
        cnt = $countones(wr_sel);
        idx = 0;
        for (int i = 0; i < 16; i++) if (wr_sel[i]) idx = i;
        for (int z = 0; z < 2; z++) begin
            eff = (cnt == 1) && !(z == 1 && idx == 0);
            model_read(z, int'(rd_addr_a), eff, idx, e_da[z], e_va[z]);
            model_read(z, int'(rd_addr_b), eff, idx, e_db[z], e_vb[z]);
            e_err[z] = (cnt >= 2);
            if (eff) mem[z][idx] = wr_data;
            if (clr_valid) begin
                for (int i = 0; i < 16; i++) vmb[z][i] = (z == 1 && i == 0);
            end else if (eff) begin
                vmb[z][idx] = 1'b1;
            end
            for (int i = 0; i < 16; i++) e_vm[z][i] = vmb[z][i];
        end
    endtask

    task automatic compare_all();
        for (int z = 0; z < 2; z++) begin
            check($sformatf("d%0d rd_data_a", z), 32'(rda[z]), 32'(e_da[z]));
            check($sformatf("d%0d rd_vld_a", z),  32'(va[z]),  32'(e_va[z]));
            check($sformatf("d%0d rd_data_b", z), 32'(rdb[z]), 32'(e_db[z]));
            check($sformatf("d%0d rd_vld_b", z),  32'(vb[z]),  32'(e_vb[z]));
            check($sformatf("d%0d wr_err", z),    32'(err[z]), 32'(e_err[z]));
            check($sformatf("d%0d valid_map", z), 32'(vmap[z]), 32'(e_vm[z]));
        end
    endtask

    task automatic apply(input logic [15:0] ws, input logic [15:0] wd, input logic clr,
                         input logic [3:0] a, input logic [3:0] b);
        wr_sel = ws; wr_data = wd; clr_valid = clr; rd_addr_a = a; rd_addr_b = b;
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        tbl[0]  = '{16'h0000, 16'h0000, 1'b0, 4'd5,  4'd9, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{16'h0020, 16'hBEEF, 1'b0, 4'd0,  4'd0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0020};
        tbl[2]  = '{16'h0000, 16'h0000, 1'b0, 4'd5,  4'd5, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0020};
        tbl[3]  = '{16'h0008, 16'h1234, 1'b0, 4'd3,  4'd5, 16'h1234, 1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0028};
        tbl[4]  = '{16'h0011, 16'hFFFF, 1'b0, 4'd4,  4'd4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0028};
        tbl[5]  = '{16'h0000, 16'h0000, 1'b0, 4'd0,  4'd4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0028};
        tbl[6]  = '{16'h0400, 16'h00AA, 1'b1, 4'd10, 4'd5, 16'h00AA, 1'b0, 16'hBEEF, 1'b1, 1'b0, 16'h0000};
        tbl[7]  = '{16'h0000, 16'h0000, 1'b0, 4'd10, 4'd5, 16'h00AA, 1'b0, 16'hBEEF, 1'b0, 1'b0, 16'h0000};
        tbl[8]  = '{16'h0300, 16'h0F0F, 1'b0, 4'd8,  4'd9, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000};
        tbl[9]  = '{16'hFFFF, 16'h0F0F, 1'b0, 4'd0,  4'd3, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b1, 16'h0000};
        tbl[10] = '{16'h0000, 16'h0000, 1'b0, 4'd9,  4'd8, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};

        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            apply(tbl[i].ws, tbl[i].wd, tbl[i].clr, tbl[i].a, tbl[i].b);
            check($sformatf("tbl%0d rd_data_a", i), 32'(rda[0]),  32'(tbl[i].da));
            check($sformatf("tbl%0d rd_vld_a", i),  32'(va[0]),   32'(tbl[i].va));
            check($sformatf("tbl%0d rd_data_b", i), 32'(rdb[0]),  32'(tbl[i].db));
            check($sformatf("tbl%0d rd_vld_b", i),  32'(vb[0]),   32'(tbl[i].vb));
            check($sformatf("tbl%0d wr_err", i),    32'(err[0]),  32'(tbl[i].err));
            check($sformatf("tbl%0d valid_map", i), 32'(vmap[0]), 32'(tbl[i].vmap));
        end

        // Hardwired entry 0: write is dropped without error, reads give 0 / valid.
        apply(16'h0001, 16'h5555, 1'b0, 4'd0, 4'd0);
        check("r0 same-cycle data", 32'(rda[1]), 32'h0000);
        check("r0 same-cycle vld",  32'(va[1]),  32'h1);
        check("r0 plain bypass",    32'(rda[0]), 32'h5555);
        apply(16'h0000, 16'h0000, 1'b0, 4'd0, 4'd0);
        check("r0 read data", 32'(rda[1]), 32'h0000);
        check("r0 read vld",  32'(va[1]),  32'h1);
        check("r0 wr_err",    32'(err[1]), 32'h0);
        check("r0 plain read", 32'(rda[0]), 32'h5555);

        for (int n = 0; n < 400; n++) begin
            logic [15:0] ws;
            int r;
            int p;
            int q;
            r = $urandom_range(0, 99);
            p = $urandom_range(0, 15);
            q = (p + $urandom_range(1, 15)) % 16;
            if (r < 20)      ws = 16'h0000;
            else if (r < 80) ws = 16'h0001 << p;
            else             ws = (16'h0001 << p) | (16'h0001 << q) | (r > 95 ? 16'($urandom) : 16'h0000);
            if (n == 200) begin
                // Reset in mid-cycle: outputs drop at once and the pending write is lost.
                wr_sel = 16'h0040; wr_data = 16'h7777; clr_valid = 1'b0;
                rd_addr_a = 4'd6; rd_addr_b = 4'd6;
                #3;
                rst = 1'b1;
                #1;
                model_reset();
                compare_all();
                @(posedge clk);
                #1;
                rst = 1'b0;
                apply(16'h0000, 16'h0000, 1'b0, 4'd6, 4'd6);
                check("post-reset entry6 vld", 32'(va[0]), 32'h0);
            end
            apply(ws, 16'($urandom), ($urandom_range(0, 19) == 0),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
